// File: rtl/pi_integrator_mc.sv
// ---------------------------------------------------------------------------
// pi_integrator_mc
// Time-multiplexed PI integrator (Tustin form) shared by N_CH turbine channels:
//     y[n] = clamp(y[n-1] + A*x[n] + B*x[n-1], LOWER, UPPER)
// Per-channel x[n-1] / y[n-1] live in internal register arrays. Only the
// clamped y is stored back, which gives anti-windup for free.
//
// Pipeline (fixed latency 3, one sample per clock across channels):
//   S1  register x / channel, read x_prev[ch] and y_prev[ch]
//   S2  p1 = (A*x) >>> FRAC, p2 = (B*x_prev) >>> FRAC   (W+2 bits kept)
//   S3  sum, clamp, register outputs and write the channel state back
//
// Ports
//   clk, rst         clock, asynchronous active-low reset
//   clr              synchronous clear of every channel state
//   in_valid/in_ch/x sample input; taken when in_valid && in_ready
//   in_ready         low while in_ch matches a channel held in S1 or S2
//   init_we/init_ch/init_val  preset y_prev[init_ch] to clamp(init_val)
//   out_valid/out_ch/y/sat    registered result, sat = result was clamped
//   frame_done       registered pulse with the result of channel N_CH-1
// ---------------------------------------------------------------------------
module pi_integrator_mc #(
    parameter int           N_CH  = 8,
    parameter int           CH_W  = 3,
    parameter int           W     = 32,
    parameter int           FRAC  = 16,
    parameter logic [W-1:0] A     = 32'h0001_8000,
    parameter logic [W-1:0] B     = 32'hFFFF_8000,
    parameter logic [W-1:0] UPPER = 32'h0004_0000,
    parameter logic [W-1:0] LOWER = 32'hFFFC_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            in_valid,
    input  logic [CH_W-1:0] in_ch,
    input  logic [W-1:0]    x,
    output logic            in_ready,
    input  logic            init_we,
    input  logic [CH_W-1:0] init_ch,
    input  logic [W-1:0]    init_val,
    output logic            out_valid,
    output logic [CH_W-1:0] out_ch,
    output logic [W-1:0]    y,
    output logic            sat,
    output logic            frame_done
);

    localparam int SW = W + 2;
    localparam logic signed [SW-1:0] UPPER_X = {{2{UPPER[W-1]}}, UPPER};
    localparam logic signed [SW-1:0] LOWER_X = {{2{LOWER[W-1]}}, LOWER};
    localparam logic [CH_W-1:0]      LAST_CH = CH_W'(N_CH - 1);

    // Signed W x W product, floor-shifted by FRAC, truncated to W+2 bits.
    function automatic logic signed [SW-1:0] mul_shift(input logic [W-1:0] coef,
                                                       input logic [W-1:0] val);
        logic signed [2*W-1:0] prod;
        prod = $signed({{W{coef[W-1]}}, coef} * {{W{val[W-1]}}, val});
        prod = prod >>> FRAC;
        return prod[SW-1:0];
    endfunction

    // Saturate a W+2 bit value into [LOWER, UPPER]; MSB of result = clamped.
    function automatic logic [W:0] clamp_sat(input logic signed [SW-1:0] s);
        logic [W:0] r;
        if (s > UPPER_X) begin
            r = {1'b1, UPPER};
        end else if (s < LOWER_X) begin
            r = {1'b1, LOWER};
        end else begin
            r = {1'b0, s[W-1:0]};
        end
        return r;
    endfunction

    // pipeline registers
    logic                 s1_valid_q, s1_valid_d;
    logic [CH_W-1:0]      s1_ch_q, s1_ch_d;
    logic [W-1:0]         s1_x_q, s1_x_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [CH_W-1:0]      s2_ch_q, s2_ch_d;
    logic [W-1:0]         s2_x_q, s2_x_d;
    logic [W-1:0]         s2_yp_q, s2_yp_d;
    logic signed [SW-1:0] s2_p1_q, s2_p1_d;
    logic signed [SW-1:0] s2_p2_q, s2_p2_d;
    logic                 out_valid_q, out_valid_d;
    logic [CH_W-1:0]      out_ch_q, out_ch_d;
    logic [W-1:0]         y_q, y_d;
    logic                 sat_q, sat_d;
    logic                 frame_done_q, frame_done_d;

    // channel state
    logic [W-1:0] x_prev_q [N_CH];
    logic [W-1:0] x_prev_d [N_CH];
    logic [W-1:0] y_prev_q [N_CH];
    logic [W-1:0] y_prev_d [N_CH];

    logic                 in_ch_ok_s, init_ch_ok_s;
    logic                 in_ready_s, accept_s;
    logic signed [SW-1:0] sum_s;
    logic [W:0]           clamp_s;
    logic [W:0]           init_clamp_s;

    // Out-of-range channels only exist when N_CH is not a power of two.
    if (N_CH == (1 << CH_W)) begin : g_full_range
        assign in_ch_ok_s   = 1'b1;
        assign init_ch_ok_s = 1'b1;
    end else begin : g_part_range
        assign in_ch_ok_s   = (in_ch <= LAST_CH);
        assign init_ch_ok_s = (init_ch <= LAST_CH);
    end

    // Same-channel RAW hazard: block while that channel's state is pending.
    always_comb begin
        in_ready_s = !((s1_valid_q && (s1_ch_q == in_ch)) ||
                       (s2_valid_q && (s2_ch_q == in_ch)));
        accept_s   = in_valid && in_ready_s && in_ch_ok_s;
    end

    // S1 capture; out-of-range samples are swallowed without a valid bubble.
    always_comb begin
        s1_valid_d = accept_s;
        if (accept_s) begin
            s1_ch_d = in_ch;
            s1_x_d  = x;
        end else begin
            s1_ch_d = s1_ch_q;
            s1_x_d  = s1_x_q;
        end
    end

    // S2: state read of the S1 channel and the two coefficient products.
    always_comb begin
        s2_valid_d = s1_valid_q;
        s2_ch_d    = s1_ch_q;
        s2_x_d     = s1_x_q;
        s2_yp_d    = y_prev_q[s1_ch_q];
        s2_p1_d    = mul_shift(A, s1_x_q);
        s2_p2_d    = mul_shift(B, x_prev_q[s1_ch_q]);
    end

    // S3: accumulate and saturate; also the clamp of the preset value.
    always_comb begin
        sum_s        = $signed({{2{s2_yp_q[W-1]}}, s2_yp_q}) + s2_p1_q + s2_p2_q;
        clamp_s      = clamp_sat(sum_s);
        init_clamp_s = clamp_sat($signed({{2{init_val[W-1]}}, init_val}));
    end

    // Output register next values; fields hold between results.
    always_comb begin
        out_valid_d  = s2_valid_q;
        frame_done_d = s2_valid_q && (s2_ch_q == LAST_CH);
        if (s2_valid_q) begin
            out_ch_d = s2_ch_q;
            y_d      = clamp_s[W-1:0];
            sat_d    = clamp_s[W];
        end else begin
            out_ch_d = out_ch_q;
            y_d      = y_q;
            sat_d    = sat_q;
        end
    end

    // State update priority: clr over init over write-back.
    always_comb begin
        x_prev_d = x_prev_q;
        y_prev_d = y_prev_q;
        if (clr) begin
            for (int i = 0; i < N_CH; i++) begin
                x_prev_d[i] = {W{1'b0}};
                y_prev_d[i] = {W{1'b0}};
            end
        end else begin
            if (s2_valid_q) begin
                x_prev_d[s2_ch_q] = s2_x_q;
                y_prev_d[s2_ch_q] = clamp_s[W-1:0];
            end else begin
                x_prev_d = x_prev_q;
            end
            if (init_we && init_ch_ok_s) begin
                y_prev_d[init_ch] = init_clamp_s[W-1:0];
            end else begin
                y_prev_d = y_prev_d;
            end
        end
    end

    // Pipeline and output registers; reset drops anything in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q   <= 1'b0;
            s1_ch_q      <= {CH_W{1'b0}};
            s1_x_q       <= {W{1'b0}};
            s2_valid_q   <= 1'b0;
            s2_ch_q      <= {CH_W{1'b0}};
            s2_x_q       <= {W{1'b0}};
            s2_yp_q      <= {W{1'b0}};
            s2_p1_q      <= {SW{1'b0}};
            s2_p2_q      <= {SW{1'b0}};
            out_valid_q  <= 1'b0;
            out_ch_q     <= {CH_W{1'b0}};
            y_q          <= {W{1'b0}};
            sat_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_ch_q      <= s1_ch_d;
            s1_x_q       <= s1_x_d;
            s2_valid_q   <= s2_valid_d;
            s2_ch_q      <= s2_ch_d;
            s2_x_q       <= s2_x_d;
            s2_yp_q      <= s2_yp_d;
            s2_p1_q      <= s2_p1_d;
            s2_p2_q      <= s2_p2_d;
            out_valid_q  <= out_valid_d;
            out_ch_q     <= out_ch_d;
            y_q          <= y_d;
            sat_q        <= sat_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Per-channel state arrays.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_CH; i++) begin
                x_prev_q[i] <= {W{1'b0}};
                y_prev_q[i] <= {W{1'b0}};
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                x_prev_q[i] <= x_prev_d[i];
                y_prev_q[i] <= y_prev_d[i];
            end
        end
    end

    // in_ready is a compare of in_ch against registered pipeline tags.
    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_q;
    assign out_ch     = out_ch_q;
    assign y          = y_q;
    assign sat        = sat_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pi_integrator_mc.sv
module tb_pi_integrator_mc;

    localparam longint CA = 64'sd98304;    // 1.5 in Q16
    localparam longint CB = -64'sd32768;   // -0.5 in Q16
    localparam longint UP = 64'sd262144;   // 4.0
    localparam longint LO = -64'sd262144;  // -4.0

    logic        clk, rst, clr, in_valid, in_ready, init_we;
    logic [2:0]  in_ch, init_ch, out_ch;
    logic [31:0] x, init_val, y;
    logic        out_valid, sat, frame_done;

    pi_integrator_mc dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ch(in_ch),
        .x(x), .in_ready(in_ready), .init_we(init_we), .init_ch(init_ch),
        .init_val(init_val), .out_valid(out_valid), .out_ch(out_ch), .y(y),
        .sat(sat), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [2:0] ch; logic [31:0] x; logic [31:0] y; logic sat; } vec_t;
    typedef struct { int due; logic [2:0] ch; logic [31:0] y; logic sat; } exp_t;

    int     n_chk = 0;
    int     n_fail = 0;
    int     cyc = 0;
    exp_t   exp_q[$];
    longint m_x[8];
    longint m_y[8];
    logic   h1v, h2v;
    logic [2:0] h1c, h2c;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic longint sx(input logic [31:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint floor_q16(input longint p);
        if (p >= 64'sd0) return p / 64'sd65536;
        else return -((-p + 64'sd65535) / 64'sd65536);
    endfunction

    function automatic longint clampv(input longint s);
        if (s > UP) return UP;
        else if (s < LO) return LO;
        else return s;
    endfunction

    // Reference: one Tustin step on the model state of channel ch.
    task automatic model_step(input logic [2:0] ch, input logic [31:0] xv,
                              output logic [31:0] yo, output logic so);
        longint s, c;
        s = m_y[ch] + floor_q16(CA * sx(xv)) + floor_q16(CB * m_x[ch]);
        c = clampv(s);
        so = (c != s);
        m_y[ch] = c;
        m_x[ch] = sx(xv);
        yo = c[31:0];
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_x[i] = 64'sd0;
            m_y[i] = 64'sd0;
        end
    endtask

    // One clock: check outputs due now, drive inputs, check in_ready, update model.
    task automatic run_cycle(input logic v, input logic [2:0] ch, input logic [31:0] xv,
                             input logic c, input logic iw, input logic [2:0] ich,
                             input logic [31:0] ival, output logic acc);
        exp_t e;
        logic ev, er, so;
        logic [31:0] yo;
        @(negedge clk);
        ev = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            ev = 1'b1;
        end
        chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
        if (ev) begin
            chk("out_ch", {29'd0, out_ch}, {29'd0, e.ch});
            chk("y", y, e.y);
            chk("sat", {31'd0, sat}, {31'd0, e.sat});
            chk("frame_done", {31'd0, frame_done}, {31'd0, (e.ch == 3'd7)});
        end else begin
            chk("frame_done_idle", {31'd0, frame_done}, 32'd0);
        end
        in_valid = v; in_ch = ch; x = xv; clr = c;
        init_we = iw; init_ch = ich; init_val = ival;
        #1;
        er = !((h1v && h1c == ch) || (h2v && h2c == ch));
        chk("in_ready", {31'd0, in_ready}, {31'd0, er});
        if (c) model_reset();
        if (iw && !c) m_y[ich] = clampv(sx(ival));
        acc = v && er;
        if (acc) begin
            model_step(ch, xv, yo, so);
            e.due = cyc + 3; e.ch = ch; e.y = yo; e.sat = so;
            exp_q.push_back(e);
        end
        h2v = h1v; h2c = h1c; h1v = acc; h1c = ch;
        cyc++;
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) run_cycle(1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 3'd0, 32'd0, a);
    endtask

    // Single sample, wait the fixed latency, compare against table constants.
    task automatic send_check(input vec_t v, input int idx);
        logic [31:0] yo;
        logic so;
        @(negedge clk);
        in_valid = 1'b1; in_ch = v.ch; x = v.x;
        #1;
        chk($sformatf("tbl%0d_ready", idx), {31'd0, in_ready}, 32'd1);
        model_step(v.ch, v.x, yo, so);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk($sformatf("tbl%0d_valid", idx), {31'd0, out_valid}, 32'd1);
        chk($sformatf("tbl%0d_ch", idx), {29'd0, out_ch}, {29'd0, v.ch});
        chk($sformatf("tbl%0d_y", idx), y, v.y);
        chk($sformatf("tbl%0d_sat", idx), {31'd0, sat}, {31'd0, v.sat});
    endtask

    initial begin
        vec_t tbl[10];
        logic acc;
        int   stalls;
        logic [2:0]  rch, last_ch;
        logic [31:0] rx;

        tbl[0] = '{3'd0, 32'h0001_0000, 32'h0001_8000, 1'b0};
        tbl[1] = '{3'd0, 32'h0001_0000, 32'h0002_8000, 1'b0};
        tbl[2] = '{3'd0, 32'h0001_0000, 32'h0003_8000, 1'b0};
        tbl[3] = '{3'd0, 32'h0001_0000, 32'h0004_0000, 1'b1};
        tbl[4] = '{3'd0, 32'h0001_0000, 32'h0004_0000, 1'b1};
        tbl[5] = '{3'd0, 32'h0000_0000, 32'h0003_8000, 1'b0};
        tbl[6] = '{3'd1, 32'hFFFF_0000, 32'hFFFE_8000, 1'b0};
        tbl[7] = '{3'd1, 32'hFFFF_0000, 32'hFFFD_8000, 1'b0};
        tbl[8] = '{3'd1, 32'hFFFF_0000, 32'hFFFC_8000, 1'b0};
        tbl[9] = '{3'd1, 32'hFFFF_0000, 32'hFFFC_0000, 1'b1};

        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_ch = 3'd0; x = 32'd0;
        init_we = 1'b0; init_ch = 3'd0; init_val = 32'd0;
        h1v = 1'b0; h2v = 1'b0; h1c = 3'd0; h2c = 3'd0;
        model_reset();
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_y", y, 32'd0);
        chk("rst_sat", {31'd0, sat}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst_out_ch", {29'd0, out_ch}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b1;

        // T1/T2/T6 from the table
        for (int i = 0; i < 10; i++) send_check(tbl[i], i);

        // T3 back-to-back channels after a clear, then same-channel hazard
        run_cycle(1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 3'd0, 32'd0, acc);
        for (int c = 0; c < 8; c++)
            run_cycle(1'b1, 3'(c), 32'(c) << 16, 1'b0, 1'b0, 3'd0, 32'd0, acc);
        idle(4);
        run_cycle(1'b1, 3'd3, 32'h0001_0000, 1'b0, 1'b0, 3'd0, 32'd0, acc);
        stalls = 0;
        acc = 1'b0;
        for (int k = 0; k < 6 && !acc; k++) begin
            run_cycle(1'b1, 3'd3, 32'h0002_0000, 1'b0, 1'b0, 3'd0, 32'd0, acc);
            if (!acc) stalls++;
        end
        chk("hazard_stalls", 32'(stalls), 32'd2);
        idle(4);

        // T4 preset (clamped both ways) and clear
        run_cycle(1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 3'd0, 32'd0, acc);
        run_cycle(1'b0, 3'd0, 32'd0, 1'b0, 1'b1, 3'd2, 32'h0010_0000, acc);
        run_cycle(1'b1, 3'd2, 32'd0, 1'b0, 1'b1, 3'd6, 32'h8000_0000, acc);
        run_cycle(1'b1, 3'd6, 32'd0, 1'b0, 1'b0, 3'd0, 32'd0, acc);
        idle(4);
        run_cycle(1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 3'd0, 32'd0, acc);
        run_cycle(1'b1, 3'd2, 32'd0, 1'b0, 1'b0, 3'd0, 32'd0, acc);
        idle(4);

        // init and clr colliding with an S3 write-back
        run_cycle(1'b1, 3'd4, 32'h0001_0000, 1'b0, 1'b0, 3'd0, 32'd0, acc);
        run_cycle(1'b1, 3'd5, 32'h0001_0000, 1'b0, 1'b0, 3'd0, 32'd0, acc);
        run_cycle(1'b0, 3'd0, 32'd0, 1'b0, 1'b1, 3'd4, 32'h0000_5000, acc);
        run_cycle(1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 3'd0, 32'd0, acc);
        idle(3);
        run_cycle(1'b1, 3'd4, 32'h0000_0000, 1'b0, 1'b0, 3'd0, 32'd0, acc);
        run_cycle(1'b1, 3'd5, 32'h0000_0000, 1'b0, 1'b0, 3'd0, 32'd0, acc);
        idle(4);

        // randomized traffic with frequent channel repeats
        last_ch = 3'd0;
        for (int n = 0; n < 400; n++) begin
            rch = ($urandom_range(0, 3) == 0) ? last_ch : 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) rx = $urandom;
            else rx = 32'($urandom_range(0, 393216)) - 32'h0003_0000;
            run_cycle($urandom_range(0, 3) != 0, rch, rx, 1'b0, 1'b0, 3'd0, 32'd0, acc);
            last_ch = rch;
        end
        idle(4);

        // T5 reset with samples in flight
        @(negedge clk);
        in_valid = 1'b1; in_ch = 3'd0; x = 32'h0001_0000;
        @(negedge clk);
        in_ch = 3'd1;
        @(negedge clk);
        in_ch = 3'd2;
        #1 rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_y", y, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("midrst_no_valid", {31'd0, out_valid}, 32'd0);
        end
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst_no_valid", {31'd0, out_valid}, 32'd0);
        end
        model_reset();
        exp_q.delete();
        h1v = 1'b0; h2v = 1'b0;
        run_cycle(1'b1, 3'd0, 32'h0001_0000, 1'b0, 1'b0, 3'd0, 32'd0, acc);
        idle(4);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
